tensor_core_pingpong_register_file: RTL

//  Parametrised, double-buffered operand store for the tensor core. Two banks of NUM_MATRICES DIMxDIM signed matrices.
//  The tensor core reads and writes back the ACTIVE bank in bulk. A lane-wide valid/ready stream fills the SHADOW bank.
//  A swap exchanges the two banks, so loading the next operands overlaps compute on the current ones.

---
 rtl/tensor_core_pingpong_register_file.sv | 99 +++++++++
 1 files changed

// File: rtl/tensor_core_pingpong_register_file.sv
// tensor_core_pingpong_register_file: double-buffered operand store, active bank for the core, shadow bank streamed in
module tensor_core_pingpong_register_file #(
    parameter int DATA_WIDTH = 8,
    parameter int DIM = 3,
    parameter int NUM_MATRICES = 2,
    parameter int LANES = 4,
    localparam int TOTAL = NUM_MATRICES * DIM * DIM,
    localparam int AW = $clog2(TOTAL)
) (
    input  logic clock_in,
    input  logic reset_n_in,
    input  logic load_start_in,
    input  logic load_valid_in,
    output logic load_ready_out,
    input  logic [LANES-1:0][DATA_WIDTH-1:0] load_data_in,
    output logic shadow_full_out,
    input  logic swap_in,
    output logic swap_done_out,
    output logic active_bank_out,
    output logic [NUM_MATRICES-1:0][DIM-1:0][DIM-1:0][DATA_WIDTH-1:0] bulk_read_data_out,
    input  logic bulk_write_enable_in,
    input  logic [NUM_MATRICES-1:0][DIM-1:0][DIM-1:0][DATA_WIDTH-1:0] bulk_write_data_in,
    input  logic single_write_enable_in,
    input  logic [AW-1:0] single_addr_in,
    input  logic [DATA_WIDTH-1:0] single_write_data_in,
    output logic [DATA_WIDTH-1:0] single_read_data_out
);
    localparam int PW = $clog2(TOTAL + LANES);
    localparam int LW = LANES > 1 ? $clog2(LANES) : 1;
    localparam logic [AW:0] TOTAL_W = TOTAL;
    typedef enum logic [1:0] {IDLE, LOADING, FULL} state_t;
    state_t state, state_n;
    logic [PW-1:0] ptr, ptr_n;
    logic beat, do_swap, shadow;
    logic [1:0][TOTAL-1:0][DATA_WIDTH-1:0] mem, mem_n;
    logic [TOTAL-1:0][DATA_WIDTH-1:0] bulk_flat;

    assign shadow = ~active_bank_out;
    assign bulk_flat = bulk_write_data_in;
    assign bulk_read_data_out = mem[active_bank_out];
    assign load_ready_out = state == LOADING;
    assign shadow_full_out = state == FULL;
    assign beat = load_ready_out && load_valid_in && !load_start_in;
    assign do_swap = shadow_full_out && swap_in;

    // state, fill pointer, bank select and swap pulse
    always_ff @(posedge clock_in) begin
        if (!reset_n_in) begin
            state <= IDLE;
            ptr <= '0;
            active_bank_out <= 1'b0;
            swap_done_out <= 1'b0;
        end else begin
            state <= state_n;
            ptr <= ptr_n;
            active_bank_out <= active_bank_out ^ do_swap;
            swap_done_out <= do_swap;
        end
    end

    // next state: a final beat fills the bank, a restart always wins
    always_comb begin
        state_n = state;
        ptr_n = ptr;
        if (do_swap) state_n = IDLE;
        if (beat) begin
            state_n = (ptr + PW'(LANES) >= PW'(TOTAL)) ? FULL : LOADING;
            ptr_n = (ptr + PW'(LANES) >= PW'(TOTAL)) ? '0 : ptr + PW'(LANES);
        end
        if (load_start_in) begin
            state_n = LOADING;
            ptr_n = '0;
        end
    end

    // per-element write select: stream beat beats debug write; bulk only reaches the active bank
    for (genvar b = 0; b < 2; b++) begin : g_bank
        for (genvar e = 0; e < TOTAL; e++) begin : g_elem
            logic own_shadow, stream_hit, single_hit;
            assign own_shadow = shadow == 1'(b);
            assign stream_hit = beat && own_shadow && PW'(e) >= ptr && PW'(e) < ptr + PW'(LANES);
            assign single_hit = single_write_enable_in && own_shadow && single_addr_in == AW'(e);
            assign mem_n[b][e] = stream_hit ? load_data_in[LW'(e) - ptr[LW-1:0]] :
                                 single_hit ? single_write_data_in :
                                 (bulk_write_enable_in && !own_shadow) ? bulk_flat[e] : mem[b][e];
        end
    end

    // bank storage
    always_ff @(posedge clock_in) begin
        mem <= reset_n_in ? mem_n : '0;
    end

    // debug read of the shadow bank as it stands before this edge's writes
    always_ff @(posedge clock_in) begin
        if (!reset_n_in) single_read_data_out <= '0;
        else single_read_data_out <= ({1'b0, single_addr_in} < TOTAL_W) ? mem[shadow][single_addr_in] : '0;
    end
endmodule
